// File: rtl/sha_msg_pkg.sv
// Shared types and defaults for the SHA-256 engine's message memory responder.
package sha_msg_pkg;

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_KICK,
        ST_ARM,
        ST_RUN,
        ST_DUMP_RD,
        ST_DUMP_OUT
    } msg_state_t;

    localparam logic [15:0] MSG_BASE_D = 16'h0000;
    localparam logic [15:0] OUT_BASE_D = 16'h0100;
    localparam int          HASH_WORDS = 8;
    localparam int          HASH_IDX_W = $clog2(HASH_WORDS);

endpackage

// File: rtl/sha_msg_mem_if.sv
// Host load/result streams, engine control and engine memory port of sha_msg_mem.
interface sha_msg_mem_if;
    logic        host_valid;
    logic        host_ready;
    logic [31:0] host_data;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        res_last;
    logic        start;
    logic        done;
    logic [15:0] message_addr;
    logic [15:0] output_addr;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic        busy;
    logic        err;

    modport slave (
        input  host_valid, host_data, res_ready, done, mem_we, mem_addr, mem_write_data,
        output host_ready, res_valid, res_data, res_last, start, message_addr, output_addr,
               mem_read_data, busy, err
    );

    modport master (
        output host_valid, host_data, res_ready, done, mem_we, mem_addr, mem_write_data,
        input  host_ready, res_valid, res_data, res_last, start, message_addr, output_addr,
               mem_read_data, busy, err
    );
endinterface

// File: rtl/sha_word_ram.sv
// Single-port word RAM with registered, old-data read; the port owner (host load,
// engine, or dump) is chosen by the controller state. Out-of-range writes are dropped.
module sha_word_ram
    import sha_msg_pkg::*;
#(
    parameter int          DEPTH    = 512,
    parameter logic [15:0] MSG_BASE = MSG_BASE_D,
    parameter logic [15:0] OUT_BASE = OUT_BASE_D
) (
    input  logic                  clk,
    input  msg_state_t            state,
    input  logic [15:0]           load_idx,
    input  logic [HASH_IDX_W-1:0] dump_idx,
    input  logic                  host_we,
    input  logic [31:0]           host_wdata,
    input  logic                  eng_we,
    input  logic [15:0]           eng_addr,
    input  logic [31:0]           eng_wdata,
    output logic [31:0]           rd_data
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0] mem [DEPTH];
    logic [15:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic        in_range;

    assign in_range = {1'b0, addr} < 17'(DEPTH);

    always_comb begin
        addr  = eng_addr;
        wdata = eng_wdata;
        we    = 1'b0;
        re    = 1'b0;
        case (state)
            ST_LOAD: begin
                addr  = MSG_BASE + load_idx;
                wdata = host_wdata;
                we    = host_we;
            end
            ST_ARM, ST_RUN: begin
                we = eng_we;
                re = 1'b1;
            end
            ST_DUMP_RD: begin
                addr = OUT_BASE + 16'(dump_idx);
                re   = 1'b1;
            end
            default: ;
        endcase
    end

    // Read samples the pre-write contents, so a same-cycle read/write returns old data.
    always_ff @(posedge clk) begin
        if (we && in_range) mem[addr[AW-1:0]] <= wdata;
        if (re)             rd_data <= mem[addr[AW-1:0]];
    end
endmodule

// File: rtl/sha_msg_mem.sv
// Loads a message, kicks the SHA engine, serves its 1-cycle-latency memory port, then
// streams the 8 hash words; host_ready/res_valid provide back-pressure outside LOAD/DUMP_OUT.
module sha_msg_mem
    import sha_msg_pkg::*;
#(
    parameter int          DEPTH        = 512,
    parameter int          NUM_OF_WORDS = 20,
    parameter logic [15:0] MSG_BASE     = MSG_BASE_D,
    parameter logic [15:0] OUT_BASE     = OUT_BASE_D,
    parameter int          TIMEOUT      = 4096
) (
    input  logic          clk,
    input  logic          reset,
    sha_msg_mem_if.slave  bus
);
    localparam int                    WD_W      = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0]       WD_LAST   = WD_W'(TIMEOUT - 1);
    localparam logic [HASH_IDX_W-1:0] DUMP_LAST = HASH_IDX_W'(HASH_WORDS - 1);
    localparam logic [15:0]           LOAD_LAST = 16'(NUM_OF_WORDS - 1);

    msg_state_t            state, state_nxt;
    logic [15:0]           load_idx;
    logic [HASH_IDX_W-1:0] dump_idx;
    logic [WD_W-1:0]       wd_cnt;
    logic [31:0]           rd_q, hold_q, mem_rd;
    logic                  eng_sel_q, oor_q, err_q;
    logic                  host_fire, eng_win, eng_oor, wd_expire;

    assign eng_win   = (state == ST_ARM) || (state == ST_RUN);
    assign host_fire = bus.host_valid && bus.host_ready;
    assign eng_oor   = {1'b0, bus.mem_addr} >= 17'(DEPTH);
    assign wd_expire = eng_win && (wd_cnt == WD_LAST);

    sha_word_ram #(.DEPTH(DEPTH), .MSG_BASE(MSG_BASE), .OUT_BASE(OUT_BASE)) u_ram (
        .clk       (clk),
        .state     (state),
        .load_idx  (load_idx),
        .dump_idx  (dump_idx),
        .host_we   (host_fire),
        .host_wdata(bus.host_data),
        .eng_we    (bus.mem_we),
        .eng_addr  (bus.mem_addr),
        .eng_wdata (bus.mem_write_data),
        .rd_data   (rd_q)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= ST_LOAD;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_LOAD:     if (host_fire && load_idx == LOAD_LAST) state_nxt = ST_KICK;
            ST_KICK:     state_nxt = ST_ARM;
            ST_ARM:      if (wd_expire) state_nxt = ST_LOAD;
                         else if (!bus.done) state_nxt = ST_RUN;
            ST_RUN:      if (wd_expire) state_nxt = ST_LOAD;
                         else if (bus.done) state_nxt = ST_DUMP_RD;
            ST_DUMP_RD:  state_nxt = ST_DUMP_OUT;
            ST_DUMP_OUT: if (bus.res_ready) state_nxt = (dump_idx == DUMP_LAST) ? ST_LOAD : ST_DUMP_RD;
            default:     state_nxt = ST_LOAD;
        endcase
    end

    // Engine read data is live only for reads issued in ARM/RUN; otherwise hold the last value.
    assign mem_rd = eng_sel_q ? (oor_q ? 32'h0 : rd_q) : hold_q;

    always_comb begin
        bus.host_ready    = (state == ST_LOAD) && !reset;
        bus.start         = (state == ST_KICK);
        bus.res_valid     = (state == ST_DUMP_OUT);
        bus.res_last      = (state == ST_DUMP_OUT) && (dump_idx == DUMP_LAST);
        bus.res_data      = (state == ST_DUMP_OUT) ? rd_q : 32'h0;
        bus.busy          = (state != ST_LOAD);
        bus.err           = err_q;
        bus.message_addr  = MSG_BASE;
        bus.output_addr   = OUT_BASE;
        bus.mem_read_data = mem_rd;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            load_idx  <= '0;
            dump_idx  <= '0;
            wd_cnt    <= '0;
            err_q     <= 1'b0;
            eng_sel_q <= 1'b0;
            oor_q     <= 1'b0;
            hold_q    <= '0;
        end else begin
            if (host_fire) load_idx <= (load_idx == LOAD_LAST) ? 16'd0 : load_idx + 16'd1;
            if (state == ST_RUN)
                dump_idx <= '0;
            else if (state == ST_DUMP_OUT && bus.res_ready)
                dump_idx <= dump_idx + 1'b1;
            wd_cnt <= eng_win ? wd_cnt + 1'b1 : '0;
            if (wd_expire || (eng_win && eng_oor) || (!eng_win && bus.mem_we))
                err_q <= 1'b1;
            eng_sel_q <= eng_win;
            oor_q     <= eng_oor;
            hold_q    <= mem_rd;
        end
    end
endmodule
